// File: rtl/seq_cmp_defs_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding,
// one-hot result encoding and the WIDTH/DIGIT legality check macro.
`ifndef SEQ_CMP_DEFS_PKG_SV
`define SEQ_CMP_DEFS_PKG_SV

// Elaboration-time guard: operands must split into a whole number of digits.
`define SEQ_CMP_CHECK_PARAMS(W, D) \
    if ((D) < 1 || (W) < (D) || ((W) % (D)) != 0) begin : g_bad_params \
        $error("seq_mag_comparator: WIDTH must be a non-zero multiple of DIGIT"); \
    end

package seq_cmp_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result vector layout is {equal, greater, lesser}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

`endif

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational DIGIT-wide magnitude compare using the classic xnor/and-or
// cascade; invert_msb biases the top bit for two's-complement digits.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             invert_msb,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [DIGIT-1:0] xm;
    logic [DIGIT-1:0] ym;
    logic             eq_run;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path through the block can leave one unassigned and infer a latch.
    always_comb begin
        xm     = x;
        ym     = y;
        gt     = 1'b0;
        lt     = 1'b0;
        eq_run = 1'b1;
        if (invert_msb) begin
            xm[DIGIT-1] = ~x[DIGIT-1];
            ym[DIGIT-1] = ~y[DIGIT-1];
        end
        // A bit decides the result only if every more significant bit matched.
        for (int i = DIGIT - 1; i >= 0; i--) begin
            gt     = gt | (eq_run & xm[i] & ~ym[i]);
            lt     = lt | (eq_run & ~xm[i] & ym[i]);
            eq_run = eq_run & ~(xm[i] ^ ym[i]);
        end
        eq = eq_run;
    end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit and valid/ready
// on both sides. Define SEQ_CMP_MINMAX_EN to add registered min_out/max_out.
module seq_mag_comparator
    import seq_cmp_defs::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DIGIT = 4,
    localparam int NDIG  = WIDTH / DIGIT,
    localparam int IDXW  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             greater,
    output logic             lesser,
    output logic [IDXW:0]    digits_used
`ifdef SEQ_CMP_MINMAX_EN
    ,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
`endif
);

    `SEQ_CMP_CHECK_PARAMS(WIDTH, DIGIT)

    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NDIG - 1);
    localparam logic [IDXW:0]   NDIG_CNT = (IDXW + 1)'(NDIG);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [2:0]       res_q, res_d;
    logic [IDXW:0]    used_q, used_d;
`ifdef SEQ_CMP_MINMAX_EN
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
`endif

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dig_invert;
    logic             dig_gt;
    logic             dig_lt;
    logic             dig_eq;

    // Mux-by-loop keeps the select in range even when NDIG is not a power of 2.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_dig = a_q[i*DIGIT +: DIGIT];
                b_dig = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    assign dig_invert = signed_q && (idx_q == IDX_TOP);

    digit_cmp #(
        .DIGIT (DIGIT)
    ) u_digit_cmp (
        .x          (a_dig),
        .y          (b_dig),
        .invert_msb (dig_invert),
        .gt         (dig_gt),
        .lt         (dig_lt),
        .eq         (dig_eq)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        res_d    = res_q;
        used_d   = used_q;
`ifdef SEQ_CMP_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = signed_mode;
                    idx_d    = IDX_TOP;
                    state_d  = ST_CMP;
                end
            end
            ST_CMP: begin
                if (!dig_eq) begin
                    res_d   = dig_gt ? RES_GT : (dig_lt ? RES_LT : RES_NONE);
                    used_d  = NDIG_CNT - {1'b0, idx_q};
                    state_d = ST_DONE;
                end else if (idx_q == '0) begin
                    res_d   = RES_EQ;
                    used_d  = NDIG_CNT;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`ifdef SEQ_CMP_MINMAX_EN
                // On equality dig_gt is low, so both outputs take A.
                if (state_d == ST_DONE) begin
                    min_d = dig_gt ? b_q : a_q;
                    max_d = dig_gt ? a_q : b_q;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            res_q    <= RES_NONE;
            used_q   <= '0;
`ifdef SEQ_CMP_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            used_q   <= used_d;
`ifdef SEQ_CMP_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    assign in_ready                  = (state_q == ST_IDLE);
    assign out_valid                 = (state_q == ST_DONE);
    assign {equal, greater, lesser}  = res_q;
    assign digits_used               = used_q;
`ifdef SEQ_CMP_MINMAX_EN
    assign min_out                   = min_q;
    assign max_out                   = max_q;
`endif

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=16, DIGIT=4): directed
// cases, reset abort and randomized transactions against an arithmetic model.
module tb_seq_mag_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             equal;
    logic             greater;
    logic             lesser;
    logic [2:0]       digits_used;
`ifdef SEQ_CMP_MINMAX_EN
    logic [WIDTH-1:0] min_out;
    logic [WIDTH-1:0] max_out;
`endif

    int checks = 0;
    int errors = 0;

    seq_mag_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .equal       (equal),
        .greater     (greater),
        .lesser      (lesser),
        .digits_used (digits_used)
`ifdef SEQ_CMP_MINMAX_EN
        ,
        .min_out     (min_out),
        .max_out     (max_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer compare under the chosen mode; the digit count is
    // the position of the most significant differing digit counted from the top.
    task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input bit ms,
                         output logic [2:0] res, output int used);
        int  va;
        int  vb;
        bit  found;
        logic [WIDTH-1:0] diff;
        va    = ms ? int'($signed(ma)) : int'(ma);
        vb    = ms ? int'($signed(mb)) : int'(mb);
        res   = (va == vb) ? 3'b100 : ((va > vb) ? 3'b010 : 3'b001);
        diff  = ma ^ mb;
        used  = NDIG;
        found = 1'b0;
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (!found && (((diff >> (DIGIT * d)) & 16'h000F) != 16'h0000)) begin
                used  = NDIG - d;
                found = 1'b1;
            end
        end
    endtask

    task automatic check_results(input string tag, input logic [2:0] exp_res, input int exp_used,
                                 input logic [WIDTH-1:0] emin, input logic [WIDTH-1:0] emax);
        check({tag, " eq/gt/lt"}, {equal, greater, lesser}, exp_res);
        check({tag, " digits_used"}, digits_used, exp_used);
`ifdef SEQ_CMP_MINMAX_EN
        check({tag, " min_out"}, min_out, emin);
        check({tag, " max_out"}, max_out, emax);
`else
        if (emin > emax) begin
            // Model-only sanity: min never exceeds max under unsigned view when unsigned.
        end
`endif
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input bit ts,
                           input int stall, input string tag);
        logic [2:0]       exp_res;
        int               exp_used;
        int               edges;
        logic [WIDTH-1:0] emin;
        logic [WIDTH-1:0] emax;
        model(ta, tb, ts, exp_res, exp_used);
        emin = (exp_res == 3'b010) ? tb : ta;
        emax = (exp_res == 3'b010) ? ta : tb;

        @(negedge clk);
        check({tag, " in_ready before accept"}, in_ready, 1);
        a           = ta;
        b           = tb;
        signed_mode = ts;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = 1'($urandom);

        edges = 0;
        while (!out_valid && edges < 20) begin
            in_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check({tag, " latency"}, edges, exp_used);
        check_results(tag, exp_res, exp_used, emin, emax);
        check({tag, " in_ready in DONE"}, in_ready, 0);

        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, " stall out_valid"}, out_valid, 1);
            check({tag, " stall in_ready"}, in_ready, 0);
            check_results({tag, " stall"}, exp_res, exp_used, emin, emax);
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " out_valid after release"}, out_valid, 0);
        check({tag, " in_ready after release"}, in_ready, 1);
        check_results({tag, " held in IDLE"}, exp_res, exp_used, emin, emax);
    endtask

    initial begin
        int               seen_valid;
        int               kind;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               d;
        logic [WIDTH-1:0] nz;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset eq/gt/lt", {equal, greater, lesser}, 3'b000);
        check("reset digits_used", digits_used, 0);
        rst = 1'b0;

        run_txn(16'h1234, 16'h1234, 1'b0, 0, "eq_1234");
        run_txn(16'h8000, 16'h7FFF, 1'b0, 0, "u_8000_7fff");
        run_txn(16'h8000, 16'h7FFF, 1'b1, 0, "s_8000_7fff");
        run_txn(16'h1235, 16'h1234, 1'b0, 0, "u_1235_1234");
        run_txn(16'hFFFF, 16'hFFFE, 1'b1, 0, "s_ffff_fffe");
        run_txn(16'h0010, 16'h0100, 1'b0, 6, "backpressure");
        run_txn(16'h8001, 16'h0005, 1'b1, 1, "s_minmax");
        run_txn(16'h8001, 16'h0005, 1'b0, 1, "u_minmax");

        // Abort a transaction mid-compare: it must vanish without a result.
        @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'hAAAA;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort eq/gt/lt", {equal, greater, lesser}, 3'b000);
        check("abort digits_used", digits_used, 0);
        seen_valid = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("abort no out_valid", seen_valid, 0);
        run_txn(16'h0001, 16'h0000, 1'b0, 0, "after_abort");

        for (int t = 0; t < 40; t++) begin
            ra   = 16'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                rb = 16'($urandom);
            end else if (kind == 3) begin
                rb = ra;
            end else begin
                d  = $urandom_range(0, NDIG - 1);
                nz = 16'($urandom_range(1, 15));
                rb = ra ^ (nz << (DIGIT * d));
            end
            run_txn(ra, rb, 1'($urandom), $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
